// File: rtl/alu_pkg.sv
// Shared definitions for the serial Y86-64 adder: FSM states, op codes, default sizes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam int ALU_WIDTH = 64;
  localparam int ALU_CHUNK = 8;

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit ripple-carry adder; cin_msb is the carry into the top cell, used for overflow.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cin_msb
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout    = carry[CHUNK];
  assign cin_msb = carry[CHUNK-1];

endmodule

// File: rtl/alu_serial_add.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock, start/done handshake.
// Define ALU_SERIAL_ADD_FLAGS_EN to generate zf/sf/of; otherwise they are tied to 0.
module alu_serial_add
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CHUNK = ALU_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  alu_state_e state_reg, state_next;

  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic             cout_reg;
  logic             accept, last;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] sum;
  logic             sum_cout, sum_cin_msb;
  logic [WIDTH-1:0] result_next;

  assign accept = start && (state_reg == IDLE || state_reg == DONE);
  assign last   = (state_reg == RUN) && (cnt_reg == CW'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Slice the latched operands so the active chunk is a plain array lookup.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
    assign result_next[gi*CHUNK +: CHUNK] =
      (cnt_reg == CW'(gi)) ? sum : result_reg[gi*CHUNK +: CHUNK];
  end

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a       (a_chunk[cnt_reg]),
    .b       (b_chunk[cnt_reg]),
    .cin     (carry_reg),
    .sum     (sum),
    .cout    (sum_cout),
    .cin_msb (sum_cin_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else if (accept) begin
      cnt_reg   <= '0;
      carry_reg <= sub;
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
    end else if (state_reg == RUN) begin
      cnt_reg    <= cnt_reg + CW'(1);
      carry_reg  <= sum_cout;
      result_reg <= result_next;
      if (last) cout_reg <= sum_cout;
    end
  end

`ifdef ALU_SERIAL_ADD_FLAGS_EN
  logic zf_reg, sf_reg, of_reg;

  // Flags are captured on the final chunk, when result_next holds the full value.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_reg <= 1'b0;
      sf_reg <= 1'b0;
      of_reg <= 1'b0;
    end else if (last) begin
      zf_reg <= (result_next == '0);
      sf_reg <= result_next[WIDTH-1];
      of_reg <= sum_cin_msb ^ sum_cout;
    end
  end

  assign zf = zf_reg;
  assign sf = sf_reg;
  assign of = of_reg;
`else
  logic unused_flag_src;
  assign unused_flag_src = sum_cin_msb;

  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign cout   = cout_reg;

endmodule

// File: tb/tb_alu_serial_add.sv
// Directed self-checking bench for alu_serial_add (flag expectations follow ALU_SERIAL_ADD_FLAGS_EN).
module tb_alu_serial_add;

`ifdef ALU_SERIAL_ADD_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [63:0] a, b;
  logic        busy, done, cout, zf, sf, of;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  alu_serial_add dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic [63:0] x, input logic [63:0] y);
    sub = s; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = 64'hDEAD_BEEF_0BAD_F00D;
    b = 64'h1357_9BDF_2468_ACE0;
    sub = ~s;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_out(input string tag, input logic [63:0] r, input logic c,
                           input logic z, input logic s, input logic o);
    check({tag, "_result"}, result, r);
    check({tag, "_cout"}, 64'(cout), 64'(c));
    check({tag, "_zf"}, 64'(zf), 64'(z & FL));
    check({tag, "_sf"}, 64'(sf), 64'(s & FL));
    check({tag, "_of"}, 64'(of), 64'(o & FL));
  endtask

  int lat;
  int ndone;

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_out("rst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Signed overflow on add
    issue(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("ovf_busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("ovf_latency", 64'(lat), 64'd8);
    check("ovf_busy_at_done", 64'(busy), 64'd0);
    check_out("ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("ovf_done_pulse", 64'(done), 64'd0);
    check("ovf_result_hold", result, 64'h8000_0000_0000_0000);

    // Subtract to zero
    issue(1'b1, 64'd5, 64'd5);
    wait_done(lat);
    check("sub0_latency", 64'(lat), 64'd8);
    check_out("sub0", 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Unsigned wrap-around
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_done(lat);
    check_out("wrap", 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // start while busy is ignored
    issue(1'b0, 64'd3, 64'd4);
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2 || i == 5) begin
        start = 1'b1; sub = 1'b1; a = 64'd100 + 64'(i); b = 64'd77;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    check("ign_result", result, 64'd7);
    check("ign_cout", 64'(cout), 64'd0);
    tick();
    if (done) ndone++;
    check("ign_done_count", 64'(ndone), 64'd1);
    check("ign_busy_after", 64'(busy), 64'd0);

    // Reset three cycles into RUN
    issue(1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0001_1111_0001_1111);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check_out("abort", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    issue(1'b0, 64'h1234, 64'h1111);
    wait_done(lat);
    check("post_abort_latency", 64'(lat), 64'd8);
    check_out("post_abort", 64'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Back-to-back accept in the DONE cycle
    issue(1'b0, 64'd1, 64'd2);
    wait_done(lat);
    check("b2b_first_result", result, 64'd3);
    issue(1'b1, 64'd0, 64'd1);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_no_bubble", 64'(done), 64'd0);
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'd8);
    check_out("b2b", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_add.md
Name: alu_serial_add

Overview:
- Multi-cycle, parametrised adder/subtractor for the sequential Y86-64 ALU.
- Processes CHUNK bits per clock through a chain of 1-bit full-adder cells, carrying between chunks in a register.
- Produces the result plus Y86 condition codes (ZF, SF, OF) and the raw carry-out.
- Uses a start/done handshake, so the execute stage can stall on busy.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; NCHUNK = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation; sampled only when not busy
- sub  in  1  0 = a+b, 1 = a-b; latched at accept
- a  in  WIDTH  operand A; latched at accept
- b  in  WIDTH  operand B; latched at accept
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result and flags valid
- result  out  WIDTH  sum/difference; held until the next accept
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow)
- zf  out  1  result == 0
- sf  out  1  result[WIDTH-1]
- of  out  1  signed overflow

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - FSM goes to IDLE.
  - busy, done, result, cout, zf, sf, of all go to 0.
  - Chunk counter and carry register clear.
  - rst overrides start in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b and sub.
  - Internal B operand = sub ? ~b : b; carry register = sub; counter = 0; go to RUN; busy=1.
- RUN:
  - Each edge adds chunk[counter] of A, B and the carry register.
  - Writes that chunk into result, updates the carry register, and increments counter.
  - On the edge that processes chunk NCHUNK-1, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly this cycle.
  - cout, zf, sf, of are valid.
  - start=1 here is accepted exactly as in IDLE (back-to-back, no bubble); otherwise go to IDLE.
- Latency:
  - Accept at edge N; done high in the cycle after edge N+NCHUNK.
  - Defaults: 8 RUN cycles, done at N+8.
- start while busy=1: ignored; latched operands and sub are unaffected.
- Input changes after accept have no effect.
- Flags:
  - of = carry-in to MSB XOR carry-out of MSB (equivalently, operand signs equal and result sign differs, using the internal B).
  - zf is computed over the full result.
  - Flags hold their values until the next accept.
- result updates chunk by chunk during RUN. Only the value at done is architectural; partial values must not be consumed.
- Reset mid-operation: aborts immediately, no done pulse, all outputs zero next cycle.
- Wrap-around: arithmetic is modulo 2^WIDTH; carry out of the top chunk goes only to cout.

Optional Feature:
- Macro: ALU_SERIAL_ADD_FLAGS_EN.
- Defined: zf, sf and of are computed as above.
- Undefined: zf, sf and of are tied to 0 and the flag logic is removed. result, cout, done, busy and latency are unchanged.

Decomposition:
- Shared package alu_pkg:
  - State enum (IDLE, RUN, DONE).
  - Op constants (ALU_ADD=0, ALU_SUB=1).
  - Default WIDTH and CHUNK constants.
- One sub-module, add_chunk: CHUNK-bit ripple of full-adder cells with inputs a, b, cin and outputs sum, cout, plus cin_msb for overflow detection on the top chunk.

Test Plan:
- add a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> result=64'h8000_0000_0000_0000, of=1, sf=1, zf=0, cout=0; done exactly 8 cycles after accept.
- sub a=5, b=5 -> result=0, zf=1, cout=1, of=0, sf=0.
- add a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, cout=1, zf=1, of=0.
- start pulsed at cycles 2 and 5 after accept with different operands -> ignored; first result correct; single done pulse.
- rst asserted 3 cycles into RUN -> next cycle busy=0, all outputs 0; no done pulse; a subsequent op completes normally.
- start held high in the DONE cycle with sub a=0, b=1 -> second op accepted with no bubble; result=64'hFFFF_FFFF_FFFF_FFFF, sf=1, cout=0; done 8 cycles later.
